// File: rtl/hnm_ssid_feeder_pkg.sv
// hnm_ssid_feeder_pkg: shared SSID geometry and helpers for the HNM request feeder.
// The SSID splits into row (MSBs) and column (LSBs): SSIDBITS = ROWINDEXBITS_HNM + COLINDEXBITS_HNM.
package hnm_ssid_feeder_pkg;

  localparam int SSIDBITS         = 12;
  localparam int ROWINDEXBITS_HNM = 5;
  localparam int COLINDEXBITS_HNM = 7;
  localparam int DEF_FIFO_DEPTH   = 16;

  typedef logic [SSIDBITS-1:0] ssid_t;

  // Round-robin favour bit: which channel wins when both are eligible.
  typedef enum logic {
    RR_HIT = 1'b0,
    RR_LKP = 1'b1
  } rr_e;

  // Pointer width for a circular FIFO: index bits plus one wrap bit.
  // Also the width needed to hold an occupancy of 0..depth.
  function automatic int ptrBits(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/hnm_ssid_feeder_if.sv
// hnm_ssid_feeder_if: upstream hit/lookup handshakes, HNMPP status and
// HNMPP request outputs of the feeder, grouped into one bundle.
// slave = the feeder itself, master = the environment driving it.
interface hnm_ssid_feeder_if
  import hnm_ssid_feeder_pkg::*;
#(
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) ();

  localparam int CNTBITS = ptrBits(FIFO_DEPTH);

  logic                        flush;
  logic                        hit_valid;
  logic                        hit_ready;
  logic [SSIDBITS-1:0]         hit_ssid;
  logic                        lkp_valid;
  logic                        lkp_ready;
  logic [SSIDBITS-1:0]         lkp_ssid;
  logic                        hnm_busy;
  logic                        hnm_writeReady;
  logic                        hnm_readReady;
  logic                        write;
  logic [SSIDBITS-1:0]         SSID_write;
  logic [ROWINDEXBITS_HNM-1:0] rowRead;
  logic                        read;
  logic [SSIDBITS-1:0]         SSID_read;
  logic [CNTBITS-1:0]          hit_count;
  logic [CNTBITS-1:0]          lkp_count;
  logic [15:0]                 drop_count;

  modport slave (
    input  flush, hit_valid, hit_ssid, lkp_valid, lkp_ssid,
           hnm_busy, hnm_writeReady, hnm_readReady,
    output hit_ready, lkp_ready, write, SSID_write, rowRead,
           read, SSID_read, hit_count, lkp_count, drop_count
  );

  modport master (
    output flush, hit_valid, hit_ssid, lkp_valid, lkp_ssid,
           hnm_busy, hnm_writeReady, hnm_readReady,
    input  hit_ready, lkp_ready, write, SSID_write, rowRead,
           read, SSID_read, hit_count, lkp_count, drop_count
  );

endinterface

// File: rtl/hnm_ssid_feeder_ssid_fifo.sv
// ssid_fifo: circular FIFO with wrap-bit pointers, synchronous flush and a
// registered occupancy count. No bypass: a pushed entry is visible at the
// head only from the next cycle. A full FIFO refuses a push even when it
// pops in the same cycle; flush wins over push and pop.
module ssid_fifo #(
  parameter  int WIDTH = 12,
  parameter  int DEPTH = 16,
  localparam int PW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] pushData,
  input  logic             pop,
  output logic [WIDTH-1:0] headData,
  output logic             full,
  output logic             empty,
  output logic [PW-1:0]    count
);

  localparam int AW = PW - 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [PW-1:0]    count_r;
  logic             full_s;
  logic             empty_s;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full_s    = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign empty_s   = (wr_ptr_r == rd_ptr_r);
  assign push_ok_s = push && !full_s && !flush;
  assign pop_ok_s  = pop && !empty_s && !flush;

  assign headData = mem_r[rd_ptr_r[AW-1:0]];
  assign full     = full_s;
  assign empty    = empty_s;
  assign count    = count_r;

  // Pointer and occupancy bookkeeping; flush returns both pointers to zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {PW{1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {PW{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + PW'(1);
        2'b01:   count_r <= count_r - PW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage array; contents are only meaningful between the pointers, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= pushData;
    end
  end

endmodule

// File: rtl/hnm_ssid_feeder.sv
// hnm_ssid_feeder: buffers hit and lookup SSIDs in two FIFOs and arbitrates
// them round-robin into single-cycle HNMPP write/read request pulses.
// Optional feature macro: HNM_FEEDER_DEDUP_EN -- drops a hit equal to the
// most recently written one while the HNM memory is known to be intact.
module hnm_ssid_feeder
  import hnm_ssid_feeder_pkg::*;
#(
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic               clk,
  input  logic               reset,
  hnm_ssid_feeder_if.slave   bus
);

  localparam int CNTBITS = ptrBits(FIFO_DEPTH);

  logic                        hit_full_s;
  logic                        hit_empty_s;
  logic [SSIDBITS-1:0]         hit_head_s;
  logic [CNTBITS-1:0]          hit_count_s;
  logic                        lkp_full_s;
  logic                        lkp_empty_s;
  logic [SSIDBITS-1:0]         lkp_head_s;
  logic [CNTBITS-1:0]          lkp_count_s;

  logic                        w_ok_s;
  logic                        r_ok_s;
  logic                        grant_w_s;
  logic                        grant_r_s;
  logic                        drop_s;
  logic                        issue_w_s;
  rr_e                         rr_next_s;

  rr_e                         rr_r;
  logic                        write_r;
  logic                        read_r;
  logic [SSIDBITS-1:0]         ssid_write_r;
  logic [SSIDBITS-1:0]         ssid_read_r;
  logic [ROWINDEXBITS_HNM-1:0] row_read_r;

  ssid_fifo #(.WIDTH(SSIDBITS), .DEPTH(FIFO_DEPTH)) u_hit_fifo (
    .clk      (clk),
    .reset    (reset),
    .flush    (bus.flush),
    .push     (bus.hit_valid && !hit_full_s),
    .pushData (bus.hit_ssid),
    .pop      (grant_w_s),
    .headData (hit_head_s),
    .full     (hit_full_s),
    .empty    (hit_empty_s),
    .count    (hit_count_s)
  );

  ssid_fifo #(.WIDTH(SSIDBITS), .DEPTH(FIFO_DEPTH)) u_lkp_fifo (
    .clk      (clk),
    .reset    (reset),
    .flush    (bus.flush),
    .push     (bus.lkp_valid && !lkp_full_s),
    .pushData (bus.lkp_ssid),
    .pop      (grant_r_s),
    .headData (lkp_head_s),
    .full     (lkp_full_s),
    .empty    (lkp_empty_s),
    .count    (lkp_count_s)
  );

  // Eligibility and round-robin grant: at most one pop per cycle, none during flush.
  always_comb begin
    grant_w_s = 1'b0;
    grant_r_s = 1'b0;
    rr_next_s = rr_r;
    w_ok_s    = !hit_empty_s && !bus.hnm_busy && bus.hnm_writeReady && !bus.flush;
    r_ok_s    = !lkp_empty_s && !bus.hnm_busy && bus.hnm_readReady && !bus.flush;
    case ({w_ok_s, r_ok_s})
      2'b11: begin
        if (rr_r == RR_HIT) begin
          grant_w_s = 1'b1;
          rr_next_s = RR_LKP;
        end else begin
          grant_r_s = 1'b1;
          rr_next_s = RR_HIT;
        end
      end
      2'b10: begin
        grant_w_s = 1'b1;
        rr_next_s = RR_LKP;
      end
      2'b01: begin
        grant_r_s = 1'b1;
        rr_next_s = RR_HIT;
      end
      default: begin
        rr_next_s = rr_r;
      end
    endcase
  end

`ifdef HNM_FEEDER_DEDUP_EN
  logic [SSIDBITS-1:0] last_ssid_r;
  logic                last_vld_r;
  logic [15:0]         drop_count_r;

  // A granted hit equal to the last written SSID is consumed silently.
  assign drop_s = grant_w_s && last_vld_r && (hit_head_s == last_ssid_r);

  // Track the last written hit; forget it whenever the memory may have been wiped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_ssid_r  <= {SSIDBITS{1'b0}};
      last_vld_r   <= 1'b0;
      drop_count_r <= 16'h0000;
    end else begin
      if (bus.flush || bus.hnm_busy) begin
        last_vld_r <= 1'b0;
      end else if (issue_w_s) begin
        last_vld_r  <= 1'b1;
        last_ssid_r <= hit_head_s;
      end
      if (drop_s && (drop_count_r != 16'hFFFF)) begin
        drop_count_r <= drop_count_r + 16'd1;
      end
    end
  end

  assign bus.drop_count = drop_count_r;
`else
  assign drop_s         = 1'b0;
  assign bus.drop_count = 16'h0000;
`endif

  assign issue_w_s = grant_w_s && !drop_s;

  // Registered HNMPP requests; SSID fields hold their value between requests.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_r         <= RR_HIT;
      write_r      <= 1'b0;
      read_r       <= 1'b0;
      ssid_write_r <= {SSIDBITS{1'b0}};
      ssid_read_r  <= {SSIDBITS{1'b0}};
      row_read_r   <= {ROWINDEXBITS_HNM{1'b0}};
    end else begin
      rr_r    <= rr_next_s;
      write_r <= issue_w_s;
      read_r  <= grant_r_s;
      if (issue_w_s) begin
        ssid_write_r <= hit_head_s;
        row_read_r   <= hit_head_s[SSIDBITS-1:COLINDEXBITS_HNM];
      end
      if (grant_r_s) begin
        ssid_read_r <= lkp_head_s;
      end
    end
  end

  assign bus.hit_ready  = !hit_full_s;
  assign bus.lkp_ready  = !lkp_full_s;
  assign bus.write      = write_r;
  assign bus.read       = read_r;
  assign bus.SSID_write = ssid_write_r;
  assign bus.SSID_read  = ssid_read_r;
  assign bus.rowRead    = row_read_r;
  assign bus.hit_count  = hit_count_s;
  assign bus.lkp_count  = lkp_count_s;

endmodule

// File: tb/tb_hnm_ssid_feeder.sv
// tb_hnm_ssid_feeder: directed scoreboard bench for hnm_ssid_feeder.
// Expected SSIDs are queued when pushed and popped when write/read pulses appear.
module tb_hnm_ssid_feeder;
  import hnm_ssid_feeder_pkg::*;

  localparam int DEPTH = DEF_FIFO_DEPTH;

  logic clk = 1'b0;
  logic reset = 1'b0;

  int errors = 0;
  int checks = 0;
  int wrCnt = 0;
  int rdCnt = 0;
  ssid_t expW[$];
  ssid_t expR[$];
  logic  issueLog[$];  // 0 = write, 1 = read

  always #5 clk = ~clk;

  hnm_ssid_feeder_if #(.FIFO_DEPTH(DEPTH)) bus ();

  hnm_ssid_feeder #(.FIFO_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pushHit(input ssid_t s, input logic expectIssue);
    bus.hit_valid = 1'b1;
    bus.hit_ssid  = s;
    if (expectIssue) expW.push_back(s);
    cyc(1);
    bus.hit_valid = 1'b0;
  endtask

  task automatic pushBoth(input ssid_t h, input ssid_t l, input logic expectIssue);
    bus.hit_valid = 1'b1;
    bus.hit_ssid  = h;
    bus.lkp_valid = 1'b1;
    bus.lkp_ssid  = l;
    if (expectIssue) begin
      expW.push_back(h);
      expR.push_back(l);
    end
    cyc(1);
    bus.hit_valid = 1'b0;
    bus.lkp_valid = 1'b0;
  endtask

  // Scoreboard monitor, sampling on the falling edge away from the active edge.
  always @(negedge clk) begin
    ssid_t e;
    if (bus.write === 1'b1) begin
      wrCnt++;
      issueLog.push_back(1'b0);
      check("write_read_exclusive", 32'(bus.read), 32'd0);
      checks++;
      assert (expW.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_write: observed SSID_write=0x%0h expected no write", bus.SSID_write);
      end
      if (expW.size() != 0) begin
        e = expW.pop_front();
        check("SSID_write", 32'(bus.SSID_write), 32'(e));
        check("rowRead", 32'(bus.rowRead), 32'(e >> COLINDEXBITS_HNM));
      end
    end
    if (bus.read === 1'b1) begin
      rdCnt++;
      issueLog.push_back(1'b1);
      checks++;
      assert (expR.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_read: observed SSID_read=0x%0h expected no read", bus.SSID_read);
      end
      if (expR.size() != 0) begin
        e = expR.pop_front();
        check("SSID_read", 32'(bus.SSID_read), 32'(e));
      end
    end
  end

  initial begin
    int w0;
    int r0;
    logic [15:0] expDrop;

    bus.flush          = 1'b0;
    bus.hit_valid      = 1'b0;
    bus.hit_ssid       = '0;
    bus.lkp_valid      = 1'b0;
    bus.lkp_ssid       = '0;
    bus.hnm_busy       = 1'b0;
    bus.hnm_writeReady = 1'b1;
    bus.hnm_readReady  = 1'b1;

    // Reset state
    #1 reset = 1'b1;
    #12;
    check("rst_write", 32'(bus.write), 32'd0);
    check("rst_read", 32'(bus.read), 32'd0);
    check("rst_SSID_write", 32'(bus.SSID_write), 32'd0);
    check("rst_SSID_read", 32'(bus.SSID_read), 32'd0);
    check("rst_rowRead", 32'(bus.rowRead), 32'd0);
    check("rst_hit_count", 32'(bus.hit_count), 32'd0);
    check("rst_lkp_count", 32'(bus.lkp_count), 32'd0);
    check("rst_drop_count", 32'(bus.drop_count), 32'd0);
    check("rst_hit_ready", 32'(bus.hit_ready), 32'd1);
    check("rst_lkp_ready", 32'(bus.lkp_ready), 32'd1);
    cyc(1);
    reset = 1'b0;
    cyc(2);

    // Single hit latency: accepted at end of cycle 0, write during cycle 2
    pushHit(12'h1A3, 1'b1);
    check("lat_write_c1", 32'(bus.write), 32'd0);
    check("lat_hit_count", 32'(bus.hit_count), 32'd1);
    cyc(1);
    check("lat_write_c2", 32'(bus.write), 32'd1);
    check("lat_SSID_write", 32'(bus.SSID_write), 32'h1A3);
    check("lat_rowRead", 32'(bus.rowRead), 32'h3);
    cyc(1);
    check("lat_one_pulse", 32'(bus.write), 32'd0);
    check("lat_hit_empty", 32'(bus.hit_count), 32'd0);
    cyc(3);

    // Interleave: reset so rr favours hits, then 5 hits + 5 lookups together
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    issueLog.delete();
    for (int i = 0; i < 5; i++) begin
      pushBoth(ssid_t'(12'h100 + i), ssid_t'(12'h200 + i), 1'b1);
    end
    cyc(12);
    check("ilv_pulses", 32'(issueLog.size()), 32'd10);
    for (int i = 0; i < 10 && i < issueLog.size(); i++) begin
      check("ilv_order", 32'(issueLog[i]), 32'(i % 2));
    end
    check("ilv_expW_drained", 32'(expW.size()), 32'd0);
    check("ilv_expR_drained", 32'(expR.size()), 32'd0);

    // Full FIFO with writeReady low, refused extra push, then a back-to-back burst
    bus.hnm_writeReady = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      pushHit(ssid_t'(12'h300 + i), 1'b1);
    end
    check("full_hit_ready", 32'(bus.hit_ready), 32'd0);
    check("full_hit_count", 32'(bus.hit_count), 32'(DEPTH));
    bus.hit_valid = 1'b1;
    bus.hit_ssid  = 12'hFFF;
    cyc(1);
    bus.hit_valid = 1'b0;
    check("full_refused", 32'(bus.hit_count), 32'(DEPTH));
    bus.hnm_writeReady = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1);
      check("burst_write", 32'(bus.write), 32'd1);
    end
    cyc(1);
    check("burst_end", 32'(bus.write), 32'd0);
    check("burst_hit_count", 32'(bus.hit_count), 32'd0);

    // Busy stall: contents kept, no pulses, order preserved afterwards
    bus.hnm_busy = 1'b1;
    pushBoth(12'h400, 12'h500, 1'b1);
    pushBoth(12'h401, 12'h501, 1'b1);
    pushHit(12'h402, 1'b1);
    w0 = wrCnt;
    r0 = rdCnt;
    cyc(20);
    check("busy_no_write", 32'(wrCnt), 32'(w0));
    check("busy_no_read", 32'(rdCnt), 32'(r0));
    check("busy_hit_count", 32'(bus.hit_count), 32'd3);
    check("busy_lkp_count", 32'(bus.lkp_count), 32'd2);
    bus.hnm_busy = 1'b0;
    cyc(8);
    check("busy_resume_w", 32'(wrCnt), 32'(w0 + 3));
    check("busy_resume_r", 32'(rdCnt), 32'(r0 + 2));

    // Dedup: 0x40,0x40,0x41,0x40 then 0x41 / busy / 0x41
    bus.hnm_writeReady = 1'b0;
`ifdef HNM_FEEDER_DEDUP_EN
    pushHit(12'h040, 1'b1);
    pushHit(12'h040, 1'b0);
    expDrop = 16'd1;
`else
    pushHit(12'h040, 1'b1);
    pushHit(12'h040, 1'b1);
    expDrop = 16'd0;
`endif
    pushHit(12'h041, 1'b1);
    pushHit(12'h040, 1'b1);
    bus.hnm_writeReady = 1'b1;
    cyc(8);
    check("dedup_drop_count", 32'(bus.drop_count), 32'(expDrop));
    check("dedup_expW_drained", 32'(expW.size()), 32'd0);
    pushHit(12'h041, 1'b1);
    cyc(4);
    bus.hnm_busy = 1'b1;
    cyc(2);
    bus.hnm_busy = 1'b0;
    pushHit(12'h041, 1'b1);
    cyc(4);
    check("dedup_busy_both", 32'(expW.size()), 32'd0);
    check("dedup_busy_drop", 32'(bus.drop_count), 32'(expDrop));

    // Async reset mid-cycle discards queued entries
    bus.hnm_busy = 1'b1;
    pushHit(12'h600, 1'b0);
    pushHit(12'h601, 1'b0);
    pushBoth(12'h602, 12'h603, 1'b0);
    check("prereset_hit_count", 32'(bus.hit_count), 32'd3);
    w0 = wrCnt;
    r0 = rdCnt;
    #2 reset = 1'b1;
    #1;
    check("async_rst_hit_count", 32'(bus.hit_count), 32'd0);
    check("async_rst_lkp_count", 32'(bus.lkp_count), 32'd0);
    check("async_rst_drop", 32'(bus.drop_count), 32'd0);
    cyc(1);
    reset = 1'b0;
    bus.hnm_busy = 1'b0;
    cyc(4);
    check("rst_no_write", 32'(wrCnt), 32'(w0));

    // Flush during a push, with entries already queued
    bus.hnm_busy = 1'b1;
    pushBoth(12'h700, 12'h710, 1'b0);
    bus.flush     = 1'b1;
    bus.hit_valid = 1'b1;
    bus.hit_ssid  = 12'h7AA;
    bus.lkp_valid = 1'b1;
    bus.lkp_ssid  = 12'h7BB;
    cyc(1);
    bus.flush     = 1'b0;
    bus.hit_valid = 1'b0;
    bus.lkp_valid = 1'b0;
    bus.hnm_busy  = 1'b0;
    check("flush_hit_count", 32'(bus.hit_count), 32'd0);
    check("flush_lkp_count", 32'(bus.lkp_count), 32'd0);
    cyc(6);
    check("flush_no_write", 32'(wrCnt), 32'(w0));
    check("flush_no_read", 32'(rdCnt), 32'(r0));
    check("final_expW_empty", 32'(expW.size()), 32'd0);
    check("final_expR_empty", 32'(expR.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
